// File: rtl/lisa_alu_issue.sv
// Issue front end for the combinational integer ALU: registered operand drive plus a tagged response FIFO.
// Optional `LISA_ALU_MUL_MULTICYCLE_EN` holds MUL operands for MUL_CYCLES edges before capture.
module lisa_alu_issue #(
  parameter int unsigned RSP_DEPTH    = 2,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned MUL_CYCLES   = 3,
  parameter logic [4:0]  LLVM_UOP_ADD = 5'h00,
  parameter logic [4:0]  LLVM_UOP_SUB = 5'h01,
  parameter logic [4:0]  LLVM_UOP_MUL = 5'h02
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_uop,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [4:0]       alu_uop,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned EW = 32 + TAG_W + 1;
  localparam logic [PW:0] DEPTH = RSP_DEPTH[PW:0];

`ifdef LISA_ALU_MUL_MULTICYCLE_EN
  localparam logic [3:0] MUL_LEN = 4'(MUL_CYCLES);
`else
  // MUL_CYCLES has no effect without the multicycle macro
  localparam logic [3:0] MUL_LEN = (MUL_CYCLES > 0) ? 4'd1 : 4'd1;
`endif

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           state_q;
  logic [3:0]       cyc_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic [4:0]       alu_uop_q;
  logic [31:0]      alu_a_q, alu_b_q;
  logic [EW-1:0]    mem_q [RSP_DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [PW:0]      count_q, count_d;

  logic             accept, push, pop, legal;
  logic [3:0]       exec_len;
  logic [EW-1:0]    head;

  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE) && (count_q < DEPTH);
    accept    = req_valid && req_ready;
    push      = (state_q == S_EXEC) && (cyc_q == 4'd1);
    rsp_valid = (count_q != '0);
    pop       = rsp_valid && rsp_ready;
    legal     = (req_uop == LLVM_UOP_ADD) || (req_uop == LLVM_UOP_SUB) ||
                (req_uop == LLVM_UOP_MUL);
    exec_len  = (req_uop == LLVM_UOP_MUL) ? MUL_LEN : 4'd1;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
      alu_uop_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            alu_uop_q <= req_uop;
            alu_a_q   <= req_a;
            alu_b_q   <= req_b;
            tag_q     <= req_tag;
            illegal_q <= !legal;
            cyc_q     <= exec_len;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          cyc_q <= cyc_q - 4'd1;
          if (push) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (push) begin
        mem_q[wr_q] <= {alu_y, tag_q, illegal_q};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head        = mem_q[rd_q];
  assign rsp_data    = head[EW-1 -: 32];
  assign rsp_tag     = head[TAG_W:1];
  assign rsp_illegal = head[0];
  assign alu_uop     = alu_uop_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign busy        = (state_q == S_EXEC) || (count_q != '0);

endmodule

// File: tb/tb_lisa_alu_issue.sv
// Directed bench for lisa_alu_issue with a behavioural ALU model on alu_*/alu_y.
module tb_lisa_alu_issue;

  localparam logic [4:0] U_ADD = 5'h00;
  localparam logic [4:0] U_SUB = 5'h01;
  localparam logic [4:0] U_MUL = 5'h02;
  localparam logic [4:0] U_BAD = 5'h1F;
`ifdef LISA_ALU_MUL_MULTICYCLE_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_illegal, busy;
  logic [4:0]  req_uop, alu_uop;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_y, rsp_data;
  logic [3:0]  req_tag, rsp_tag;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  // Reference ALU: low 32 bits, zero for unknown codes
  always_comb begin
    alu_y = '0;
    case (alu_uop)
      U_ADD: alu_y = alu_a + alu_b;
      U_SUB: alu_y = alu_a - alu_b;
      U_MUL: alu_y = alu_a * alu_b;
      default: alu_y = '0;
    endcase
  end

  lisa_alu_issue #(
    .RSP_DEPTH(2),
    .TAG_W(4),
    .MUL_CYCLES(3),
    .LLVM_UOP_ADD(U_ADD),
    .LLVM_UOP_SUB(U_SUB),
    .LLVM_UOP_MUL(U_MUL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_uop(req_uop),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_uop(alu_uop), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
    int n = 0;
    req_uop = u; req_a = a; req_b = b; req_tag = t; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    while (!rsp_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_uop = '0; req_a = '0; req_b = '0; req_tag = '0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_uop", 32'(alu_uop), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // ADD 5+7, one-cycle latency and one-cycle ready drop
    rsp_ready = 1'b1;
    issue(U_ADD, 32'd5, 32'd7, 4'd3);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_ready_low", 32'(req_ready), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_data", rsp_data, 32'd12);
    chk("add_tag", 32'(rsp_tag), 32'd3);
    chk("add_illegal", 32'(rsp_illegal), 32'd0);
    chk("add_ready_back", 32'(req_ready), 32'd1);
    tick();
    chk("add_popped", 32'(rsp_valid), 32'd0);

    // wrap-around
    issue(U_SUB, 32'd0, 32'd1, 4'd5);
    wait_rsp(lat);
    chk("sub_lat", 32'(lat), 32'd1);
    chk("sub_data", rsp_data, 32'hFFFF_FFFF);
    chk("sub_tag", 32'(rsp_tag), 32'd5);
    tick();
    issue(U_MUL, 32'h0001_0000, 32'h0001_0000, 4'd6);
    wait_rsp(lat);
    chk("mulw_lat", 32'(lat), 32'(MUL_LAT));
    chk("mulw_data", rsp_data, 32'd0);
    chk("mulw_tag", 32'(rsp_tag), 32'd6);
    tick();

    // MUL 6*7 with operand hold check during EXEC
    issue(U_MUL, 32'd6, 32'd7, 4'd7);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      chk("mul_hold_a", alu_a, 32'd6);
      chk("mul_hold_b", alu_b, 32'd7);
      tick();
      lat++;
    end
    chk("mul_lat", 32'(lat), 32'(MUL_LAT));
    chk("mul_data", rsp_data, 32'd42);
    chk("mul_tag", 32'(rsp_tag), 32'd7);
    tick();

    // backpressure: third request stalls until a pop
    rsp_ready = 1'b0;
    issue(U_ADD, 32'd1, 32'd1, 4'd1);
    tick();
    issue(U_ADD, 32'd2, 32'd2, 4'd2);
    tick();
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_head_data", rsp_data, 32'd2);
    chk("bp_head_tag", 32'(rsp_tag), 32'd1);
    req_uop = U_ADD; req_a = 32'd3; req_b = 32'd3; req_tag = 4'd3; req_valid = 1'b1;
    tick();
    chk("bp_stall_ready", 32'(req_ready), 32'd0);
    chk("bp_stall_alu_a", alu_a, 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_after_pop_ready", 32'(req_ready), 32'd1);
    chk("bp_head2_data", rsp_data, 32'd4);
    chk("bp_head2_tag", 32'(rsp_tag), 32'd2);
    tick();
    req_valid = 1'b0;
    chk("bp_third_alu_a", alu_a, 32'd3);
    tick();
    chk("bp_head2_stable", rsp_data, 32'd4);
    rsp_ready = 1'b1;
    tick();
    chk("bp_head3_data", rsp_data, 32'd6);
    chk("bp_head3_tag", 32'(rsp_tag), 32'd3);
    tick();
    chk("bp_empty", 32'(rsp_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // simultaneous push and pop with one entry queued
    rsp_ready = 1'b0;
    issue(U_ADD, 32'd10, 32'd1, 4'd4);
    tick();
    issue(U_ADD, 32'd20, 32'd2, 4'd5);
    rsp_ready = 1'b1;
    tick();
    chk("pp_valid", 32'(rsp_valid), 32'd1);
    chk("pp_data", rsp_data, 32'd22);
    chk("pp_tag", 32'(rsp_tag), 32'd5);
    tick();
    chk("pp_empty", 32'(rsp_valid), 32'd0);

    // illegal uop, then a normal ADD
    issue(U_BAD, 32'd9, 32'd9, 4'd9);
    wait_rsp(lat);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_data", rsp_data, 32'd0);
    chk("ill_flag", 32'(rsp_illegal), 32'd1);
    chk("ill_tag", 32'(rsp_tag), 32'd9);
    tick();
    issue(U_ADD, 32'd9, 32'd9, 4'd10);
    wait_rsp(lat);
    chk("post_ill_data", rsp_data, 32'd18);
    chk("post_ill_flag", 32'(rsp_illegal), 32'd0);
    chk("post_ill_tag", 32'(rsp_tag), 32'd10);
    tick();

    // reset during MUL EXEC with one queued result
    rsp_ready = 1'b0;
    issue(U_ADD, 32'd1, 32'd2, 4'd1);
    tick();
    issue(U_MUL, 32'd3, 32'd4, 4'd2);
    chk("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
